vball_palette_arbiter: RTL

Shares the single-port 2048×12 palette/colour RAM between the background tile renderer, the sprite renderer and the CPU. It sits between the three requesters and the palette RAM. Each cycle it grants one access by fixed priority with a CPU starvation guard, and routes read data back with a per-requester valid strobe. It also generates the sprite engine's `col_busy`.

---
 rtl/vball_pal_pkg.sv | 25 ++
 rtl/vball_pal_rdpipe.sv | 44 ++++
 rtl/vball_palette_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/vball_pal_pkg.sv
// Shared types and constants for the palette RAM arbiter.
// Tags identify which requester owns a read travelling through the return pipe.
package vball_pal_pkg;

  localparam int PAL_AW = 11;
  localparam int PAL_DW = 12;

  // Byte lanes of the 12-bit colour word: lane 0 = [7:0], lane 1 = [11:8].
  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_ALL  = BE_LO | BE_HI;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_BG   = 2'd1,
    TAG_SP   = 2'd2,
    TAG_CPU  = 2'd3
  } pal_tag_e;

  function automatic logic [3:0] sat_inc4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/vball_pal_rdpipe.sv
// Read-return path: two-stage tag shift register aligned with the 1-cycle RAM,
// then a registered rdata capture and per-requester rvalid demux.
module vball_pal_rdpipe
  import vball_pal_pkg::*;
(
  input  logic              clk_sys,
  input  logic              reset,
  input  logic [1:0]        tag_i,
  input  logic [PAL_DW-1:0] pal_rdata_i,
  output logic [PAL_DW-1:0] rdata_o,
  output logic              bg_rvalid_o,
  output logic              sp_rvalid_o,
  output logic              cpu_rvalid_o
);

  pal_tag_e          s1_q, s2_q;
  logic [PAL_DW-1:0] rdata_q;
  logic              bg_rv_q, sp_rv_q, cpu_rv_q;

  // s1 covers the address register cycle, s2 the RAM access cycle.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_q     <= TAG_NONE;
      s2_q     <= TAG_NONE;
      rdata_q  <= '0;
      bg_rv_q  <= 1'b0;
      sp_rv_q  <= 1'b0;
      cpu_rv_q <= 1'b0;
    end else begin
      s1_q     <= pal_tag_e'(tag_i);
      s2_q     <= s1_q;
      bg_rv_q  <= (s2_q == TAG_BG);
      sp_rv_q  <= (s2_q == TAG_SP);
      cpu_rv_q <= (s2_q == TAG_CPU);
      if (s2_q != TAG_NONE) rdata_q <= pal_rdata_i;
    end
  end

  assign rdata_o      = rdata_q;
  assign bg_rvalid_o  = bg_rv_q;
  assign sp_rvalid_o  = sp_rv_q;
  assign cpu_rvalid_o = cpu_rv_q;

endmodule

// File: rtl/vball_palette_arbiter.sv
// Single-port palette RAM arbiter: bg > sp > cpu, with the CPU promoted above
// sp once it has waited CPU_MAX_WAIT (1..15) edges. Also drives sprite col_busy.
module vball_palette_arbiter
  import vball_pal_pkg::*;
#(
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              bg_req,
  input  logic [PAL_AW-1:0] bg_addr,
  output logic              bg_ack,
  output logic              bg_rvalid,
  input  logic              sp_req,
  input  logic [PAL_AW-1:0] sp_addr,
  output logic              sp_ack,
  output logic              sp_rvalid,
  output logic              sp_busy,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [PAL_AW-1:0] cpu_addr,
  input  logic [PAL_DW-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [PAL_DW-1:0] rdata,
  output logic [PAL_AW-1:0] pal_addr,
  output logic [1:0]        pal_we,
  output logic [PAL_DW-1:0] pal_wdata,
  input  logic [PAL_DW-1:0] pal_rdata
);

  localparam logic [3:0] WAIT_LIM = 4'(CPU_MAX_WAIT);

  pal_tag_e          win, rd_tag;
  logic              promote;
  logic [3:0]        cpu_wait_q, cpu_wait_d;
  logic [PAL_AW-1:0] addr_d, pal_addr_q;
  logic [1:0]        we_d, pal_we_q;
  logic [PAL_DW-1:0] pal_wdata_q;
  logic              bg_ack_q, sp_ack_q, cpu_ack_q, sp_busy_q;

  always_comb begin
    win        = TAG_NONE;
    addr_d     = pal_addr_q;
    we_d       = BE_NONE;
    rd_tag     = TAG_NONE;
    promote    = (cpu_wait_q >= WAIT_LIM);

    // bg is never pre-empted; promotion only reorders cpu against sp.
    if (bg_req)                  win = TAG_BG;
    else if (cpu_req && promote) win = TAG_CPU;
    else if (sp_req)             win = TAG_SP;
    else if (cpu_req)            win = TAG_CPU;

    case (win)
      TAG_BG:  addr_d = bg_addr;
      TAG_SP:  addr_d = sp_addr;
      TAG_CPU: addr_d = cpu_addr;
      default: addr_d = pal_addr_q;
    endcase

    if (win == TAG_CPU && cpu_we) we_d = cpu_be & BE_ALL;
    else                          rd_tag = win;

    cpu_wait_d = (cpu_req && win != TAG_CPU) ? sat_inc4(cpu_wait_q) : 4'd0;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cpu_wait_q  <= 4'd0;
      pal_addr_q  <= '0;
      pal_we_q    <= BE_NONE;
      pal_wdata_q <= '0;
      bg_ack_q    <= 1'b0;
      sp_ack_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      sp_busy_q   <= 1'b0;
    end else begin
      cpu_wait_q <= cpu_wait_d;
      pal_addr_q <= addr_d;
      pal_we_q   <= we_d;
      if (win != TAG_NONE) pal_wdata_q <= cpu_wdata;
      bg_ack_q   <= (win == TAG_BG);
      sp_ack_q   <= (win == TAG_SP);
      cpu_ack_q  <= (win == TAG_CPU);
      sp_busy_q  <= sp_req && (win != TAG_SP);
    end
  end

  vball_pal_rdpipe u_rdpipe (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .tag_i        (rd_tag),
    .pal_rdata_i  (pal_rdata),
    .rdata_o      (rdata),
    .bg_rvalid_o  (bg_rvalid),
    .sp_rvalid_o  (sp_rvalid),
    .cpu_rvalid_o (cpu_rvalid)
  );

  assign pal_addr  = pal_addr_q;
  assign pal_we    = pal_we_q;
  assign pal_wdata = pal_wdata_q;
  assign bg_ack    = bg_ack_q;
  assign sp_ack    = sp_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign sp_busy   = sp_busy_q;

endmodule
